riscv_multicycle_control: RTL and testbench
===========================================

# riscv_multicycle_control

Sequencing controller that drives the datapath ALU's `alu_control` select and every datapath enable/mux select for a multicycle RV32I subset (lw, sw, R-type, I-type ALU, beq, jal). It is the initiator for the ALU's control interface: it decodes opcode/funct fields from the instruction register, steps through fetch/decode/execute/memory/writeback states, and stalls on a memory-ready handshake. It sits beside the datapath, taking `op`, `funct3`, `funct7b5` and the ALU zero flag as inputs.

## Interface
- `RESET_STATE`, FETCH: state entered on reset (not overridable in practice; exposed for bench).
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `op`  in  7  instruction opcode (IR[6:0])
- `funct3`  in  3  IR[14:12]
- `funct7b5`  in  1  IR[30]
- `zero`  in  1  ALU zero flag of current ALU result
- `mem_ready`  in  1  memory completes access this cycle
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  0=PC, 1=ALU result register as memory address
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction/old-PC register enable
- `result_src`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `alu_src_a`  out  2  00=PC, 01=OldPC, 10=rs1 data
- `alu_src_b`  out  2  00=rs2 data, 01=ImmExt, 10=constant 4
- `imm_src`  out  2  00=I, 01=S, 10=B, 11=J
- `reg_write`  out  1  register file write enable
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `illegal_insn`  out  1  one-cycle pulse on unsupported encoding

## Operation
- Moore FSM; outputs decoded from state; `alu_control` additionally from op/funct3/funct7b5; `pc_write = pc_update | (branch & zero)`.
- States/transitions:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu op add, result_src=10; ir_write=pc_update=mem_ready. Stay until mem_ready, then DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, add (branch target). op 0000011/0100011→MEMADR; 0110011→EXECUTER; 0010011→EXECUTEI; 1100011→BEQ; 1101111→JAL; else pulse illegal_insn, →FETCH.
  - MEMADR: alu_src_a=10, alu_src_b=01, add. lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00; hold until mem_ready, →MEMWB.
  - MEMWB: result_src=01, reg_write=1, →FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1; hold (mem_write held high) until mem_ready, →FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, decoded op, →ALUWB. EXECUTEI: alu_src_b=01, otherwise same.
  - ALUWB: result_src=00, reg_write=1, →FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, branch=1, →FETCH. funct3≠000 → illegal_insn pulse, no branch.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_update=1, →ALUWB.
- ALU decode (R/I states): funct3 000→sub iff op[5]&funct7b5 else add; 010→slt; 110→or; 111→and; others→illegal_insn pulse, no reg_write, →FETCH instead of ALUWB.
- imm_src from op: I-type/lw 00, sw 01, beq 10, jal 11; don't-care elsewhere, driven 00.
- Unused mux selects driven 00; enables default 0.

## Timing
- Reset: while rst high (sampled at edge), state←FETCH; all write enables (pc_write, mem_write, ir_write, reg_write) forced 0 in the reset cycle; illegal_insn=0; selects at FETCH values.
- Reset mid-instruction aborts it; no write enable asserts in the cycle rst is high.
- Latency with mem_ready always 1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
- Each cycle mem_ready=0 in FETCH/MEMREAD/MEMWRITE adds one cycle; outputs held stable while stalled.
- illegal_insn exactly one cycle, coincident with the state that detects it.

## Structure
- Package `riscv_ctrl_pkg`: state enum, opcode constants, alu_control encodings, result/src select encodings (shared with datapath and ALU).
- Sub-module `alu_decoder` (combinational: alu_op[1:0], funct3, op[5], funct7b5 → alu_control, illegal).

## Test plan
- Reset then lw (op 0000011) with mem_ready=1 → states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 only in cycle 5, result_src=01.
- sub R-type (funct3 000, funct7b5 1) → alu_control=001 in EXECUTER; and (111)→010, or (110)→011, slt (010)→101.
- beq with zero=1 → pc_write=1 in cycle 3; zero=0 → pc_write=0, next state FETCH.
- lw with mem_ready low 3 cycles in MEMREAD → total latency 8, outputs stable during stall.
- op 1111111 → illegal_insn high for DECODE cycle only, back to FETCH, no write enable.
- rst asserted during MEMWRITE → mem_write=0 that cycle, next state FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller, datapath and ALU.
// Pure declarations: no latency, no flow control.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_multicycle_control_alu_decoder.sv
// ALU select decode from ALU op class and funct fields; flags unsupported funct3.
// Combinational, zero latency; no flow control.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          // Only R-type (op[5]) can encode sub; addi with imm[10] set stays add.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I sequencer: drives datapath enables/selects and the ALU select.
// lw 5, sw/R/I/jal 4, beq 3 cycles; stalls in FETCH/MEMREAD/MEMWRITE until mem_ready.
module riscv_multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       illegal_insn
);

  state_t     state;
  state_t     cur;
  logic [1:0] alu_op;
  logic       alu_illegal;
  logic       branch, pc_update, ir_we, mem_we, reg_we, fsm_illegal;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control),
    .illegal     (alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECUTER;
            OP_ITYPE:          state <= S_EXECUTEI;
            OP_BEQ:            state <= S_BEQ;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECUTER, S_EXECUTEI: state <= alu_illegal ? S_FETCH : S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Reset overrides the decoded state so selects show FETCH values in that cycle.
  always_comb begin
    cur         = rst ? S_FETCH : state;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    branch      = 1'b0;
    pc_update   = 1'b0;
    ir_we       = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    fsm_illegal = 1'b0;
    case (cur)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_we      = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: fsm_illegal = 1'b0;
          default: fsm_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_we     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_we = 1'b1;
      S_BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_op      = ALUOP_SUB;
        branch      = (funct3 == 3'b000);
        fsm_illegal = (funct3 != 3'b000);
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: imm_src = IMM_S;
      OP_BEQ:   imm_src = IMM_B;
      OP_JAL:   imm_src = IMM_J;
      default:  imm_src = IMM_I;
    endcase
  end

  assign pc_write     = ~rst & (pc_update | (branch & zero));
  assign ir_write     = ~rst & ir_we;
  assign mem_write    = ~rst & mem_we;
  assign reg_write    = ~rst & reg_we;
  assign illegal_insn = ~rst & (fsm_illegal |
                        (((cur == S_EXECUTER) || (cur == S_EXECUTEI)) & alu_illegal));

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Directed bench for the multicycle controller with hand-computed per-cycle vectors.
module tb_riscv_multicycle_control;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_insn;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [16:0] outs;

  int checks = 0;
  int errors = 0;

  riscv_multicycle_control #(.RESET_STATE(S_FETCH)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write), .alu_control(alu_control), .illegal_insn(illegal_insn)
  );

  always #5 clk = ~clk;

  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, imm_src, reg_write, alu_control, illegal_insn};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Fields in port order: pcw adr mw irw result a b imm rw alu ill
  function automatic logic [16:0] v(input int pcw, input int adr, input int mw, input int irw,
                                    input int rs, input int a, input int b, input int imm,
                                    input int rw, input int alu, input int ill);
    logic [16:0] r;
    r = {pcw[0], adr[0], mw[0], irw[0], rs[1:0], a[1:0], b[1:0], imm[1:0], rw[0], alu[2:0], ill[0]};
    return r;
  endfunction

  task automatic step(input string tag, input state_t es, input logic [16:0] ev);
    @(negedge clk);
    chk({tag, ".st"}, 32'(dut.state), 32'(es));
    chk({tag, ".out"}, 32'(outs), 32'(ev));
    @(posedge clk);
    #1;
  endtask

  task automatic set_insn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  int rt_f3  [5] = '{0, 7, 6, 2, 0};
  int rt_f7  [5] = '{1, 0, 0, 0, 0};
  int rt_alu [5] = '{1, 2, 3, 5, 0};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1;
    set_insn(7'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    step("reset", S_FETCH, v(0,0,0,0,2,0,2,0,0,0,0));
    rst = 1'b0;

    // lw, no stalls
    set_insn(OP_LOAD, 3'b010, 1'b0);
    step("lw.f",  S_FETCH,   v(1,0,0,1,2,0,2,0,0,0,0));
    step("lw.d",  S_DECODE,  v(0,0,0,0,0,1,1,0,0,0,0));
    step("lw.ma", S_MEMADR,  v(0,0,0,0,0,2,1,0,0,0,0));
    step("lw.mr", S_MEMREAD, v(0,1,0,0,0,0,0,0,0,0,0));
    step("lw.wb", S_MEMWB,   v(0,0,0,0,1,0,0,0,1,0,0));

    // R-type sub/and/or/slt/add
    for (int i = 0; i < 5; i++) begin
      set_insn(OP_RTYPE, 3'(rt_f3[i]), rt_f7[i][0]);
      step("r.f",  S_FETCH,    v(1,0,0,1,2,0,2,0,0,0,0));
      step("r.d",  S_DECODE,   v(0,0,0,0,0,1,1,0,0,0,0));
      step("r.ex", S_EXECUTER, v(0,0,0,0,0,2,0,0,0,rt_alu[i],0));
      step("r.wb", S_ALUWB,    v(0,0,0,0,0,0,0,0,1,0,0));
    end

    // addi with imm[10] set must stay add
    set_insn(OP_ITYPE, 3'b000, 1'b1);
    step("i.f",  S_FETCH,    v(1,0,0,1,2,0,2,0,0,0,0));
    step("i.d",  S_DECODE,   v(0,0,0,0,0,1,1,0,0,0,0));
    step("i.ex", S_EXECUTEI, v(0,0,0,0,0,2,1,0,0,0,0));
    step("i.wb", S_ALUWB,    v(0,0,0,0,0,0,0,0,1,0,0));

    // sw with one FETCH stall cycle
    set_insn(OP_STORE, 3'b010, 1'b0);
    mem_ready = 1'b0;
    step("sw.fs", S_FETCH,    v(0,0,0,0,2,0,2,1,0,0,0));
    mem_ready = 1'b1;
    step("sw.f",  S_FETCH,    v(1,0,0,1,2,0,2,1,0,0,0));
    step("sw.d",  S_DECODE,   v(0,0,0,0,0,1,1,1,0,0,0));
    step("sw.ma", S_MEMADR,   v(0,0,0,0,0,2,1,1,0,0,0));
    step("sw.mw", S_MEMWRITE, v(0,1,1,0,0,0,0,1,0,0,0));

    // beq taken, then not taken
    set_insn(OP_BEQ, 3'b000, 1'b0);
    zero = 1'b1;
    step("bt.f", S_FETCH,  v(1,0,0,1,2,0,2,2,0,0,0));
    step("bt.d", S_DECODE, v(0,0,0,0,0,1,1,2,0,0,0));
    step("bt.b", S_BEQ,    v(1,0,0,0,0,2,0,2,0,1,0));
    zero = 1'b0;
    step("bn.f", S_FETCH,  v(1,0,0,1,2,0,2,2,0,0,0));
    step("bn.d", S_DECODE, v(0,0,0,0,0,1,1,2,0,0,0));
    step("bn.b", S_BEQ,    v(0,0,0,0,0,2,0,2,0,1,0));

    // jal
    set_insn(OP_JAL, 3'b000, 1'b0);
    step("j.f",  S_FETCH,  v(1,0,0,1,2,0,2,3,0,0,0));
    step("j.d",  S_DECODE, v(0,0,0,0,0,1,1,3,0,0,0));
    step("j.j",  S_JAL,    v(1,0,0,0,0,1,2,3,0,0,0));
    step("j.wb", S_ALUWB,  v(0,0,0,0,0,0,0,3,1,0,0));

    // lw with three MEMREAD stall cycles: 8 cycles total
    set_insn(OP_LOAD, 3'b010, 1'b0);
    step("ls.f",  S_FETCH,  v(1,0,0,1,2,0,2,0,0,0,0));
    step("ls.d",  S_DECODE, v(0,0,0,0,0,1,1,0,0,0,0));
    step("ls.ma", S_MEMADR, v(0,0,0,0,0,2,1,0,0,0,0));
    mem_ready = 1'b0;
    repeat (3) step("ls.stall", S_MEMREAD, v(0,1,0,0,0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    step("ls.mr", S_MEMREAD, v(0,1,0,0,0,0,0,0,0,0,0));
    step("ls.wb", S_MEMWB,   v(0,0,0,0,1,0,0,0,1,0,0));

    // Unsupported opcode: pulse in DECODE only
    set_insn(7'b1111111, 3'b000, 1'b0);
    step("il.f", S_FETCH,  v(1,0,0,1,2,0,2,0,0,0,0));
    step("il.d", S_DECODE, v(0,0,0,0,0,1,1,0,0,0,1));

    // Unsupported R-type funct3 (sll): pulse in EXECUTER, skip writeback
    set_insn(OP_RTYPE, 3'b001, 1'b0);
    step("rl.f", S_FETCH,  v(1,0,0,1,2,0,2,0,0,0,0));
    step("rl.d", S_DECODE, v(0,0,0,0,0,1,1,0,0,0,0));
    @(negedge clk);
    chk("rl.ex.st",  32'(dut.state), 32'(S_EXECUTER));
    chk("rl.ex.ill", 32'(illegal_insn), 32'd1);
    chk("rl.ex.rw",  32'(reg_write), 32'd0);
    @(posedge clk);
    #1;

    // beq with funct3 != 000: pulse, no branch even with zero=1
    set_insn(OP_BEQ, 3'b001, 1'b0);
    zero = 1'b1;
    step("bl.f", S_FETCH,  v(1,0,0,1,2,0,2,2,0,0,0));
    step("bl.d", S_DECODE, v(0,0,0,0,0,1,1,2,0,0,0));
    step("bl.b", S_BEQ,    v(0,0,0,0,0,2,0,2,0,1,1));
    zero = 1'b0;

    // Reset during a stalled MEMWRITE
    set_insn(OP_STORE, 3'b010, 1'b0);
    step("rs.f",  S_FETCH,  v(1,0,0,1,2,0,2,1,0,0,0));
    step("rs.d",  S_DECODE, v(0,0,0,0,0,1,1,1,0,0,0));
    step("rs.ma", S_MEMADR, v(0,0,0,0,0,2,1,1,0,0,0));
    mem_ready = 1'b0;
    step("rs.mw", S_MEMWRITE, v(0,1,1,0,0,0,0,1,0,0,0));
    rst = 1'b1;
    step("rs.rst", S_MEMWRITE, v(0,0,0,0,2,0,2,1,0,0,0));
    rst = 1'b0;
    mem_ready = 1'b1;
    step("rs.after", S_FETCH, v(1,0,0,1,2,0,2,1,0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
